// File: rtl/display_manager_gen.sv
// Display page generator for the Bulls & Cows game: turns the FSM state and the
// game data into NUM_DIGITS registered display codes (slot 1 is the rightmost).
module display_manager_gen #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CODE_W       = 6,
  parameter int unsigned ENTRY_DIGITS = 4,
  parameter int unsigned BLINK_DIV    = 25000000,
  localparam int unsigned CNT_W       = $clog2(ENTRY_DIGITS + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         confirm,
  input  logic [2:0]                   current_state,
  input  logic [4*ENTRY_DIGITS-1:0]    entry_digits,
  input  logic [CNT_W-1:0]             bulls,
  input  logic [CNT_W-1:0]             cows,
  output logic [NUM_DIGITS*CODE_W-1:0] d
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SECRET_J1 = 3'd1;
  localparam logic [2:0] ST_SECRET_J2 = 3'd2;
  localparam logic [2:0] ST_GUESS_J1  = 3'd3;
  localparam logic [2:0] ST_GUESS_J2  = 3'd4;
  localparam logic [2:0] ST_WIN_J1    = 3'd5;
  localparam logic [2:0] ST_WIN_J2    = 3'd6;
  localparam logic [2:0] ST_RESULT    = 3'd7;

  localparam logic [CODE_W-1:0] CODE_BLANK = CODE_W'(6'h23);
  localparam logic [CODE_W-1:0] CODE_DASH  = CODE_W'(6'h3F);
  localparam logic [CODE_W-1:0] CODE_J     = CODE_W'(6'h37);
  localparam logic [CODE_W-1:0] CODE_B     = CODE_W'(6'h2B);
  localparam logic [CODE_W-1:0] CODE_C     = CODE_W'(6'h2F);

  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  function automatic logic [CODE_W-1:0] digit_code(input logic [3:0] v);
    if (v > 4'd9) return CODE_DASH;
    return CODE_W'(v);
  endfunction

  function automatic logic [CODE_W-1:0] count_code(input logic [CNT_W-1:0] v);
    if (32'(v) > 32'd9) return CODE_DASH;
    return CODE_W'(v);
  endfunction

  logic                                   confirm_prev_q;
  logic [2:0]                             prev_state_q;
  logic                                   mask_q, mask_d;
  logic [1:0]                             last_player_q, last_player_d;
  logic [BLINK_W-1:0]                     blink_cnt_q, blink_cnt_d;
  logic                                   visible_q, visible_d;
  logic [NUM_DIGITS-1:0][CODE_W-1:0]      d_q, d_d;
  logic [ENTRY_DIGITS-1:0][CODE_W-1:0]    entry_code;

  logic tick, entry, is_secret, is_guess, is_win;
  logic [CODE_W-1:0] player_code;

  assign tick      = confirm & ~confirm_prev_q;
  assign entry     = current_state != prev_state_q;
  assign is_secret = (current_state == ST_SECRET_J1) || (current_state == ST_SECRET_J2);
  assign is_guess  = (current_state == ST_GUESS_J1)  || (current_state == ST_GUESS_J2);
  assign is_win    = (current_state == ST_WIN_J1)    || (current_state == ST_WIN_J2);
  assign player_code = ((current_state == ST_SECRET_J1) || (current_state == ST_GUESS_J1) ||
                        (current_state == ST_WIN_J1)) ? CODE_W'(1) : CODE_W'(2);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    mask_d        = mask_q;
    last_player_d = last_player_q;
    blink_cnt_d   = blink_cnt_q;
    visible_d     = visible_q;

    // State entry re-arms the mask even if a confirm edge lands in the same cycle.
    if (is_secret) begin
      if (entry)     mask_d = 1'b1;
      else if (tick) mask_d = ~mask_q;
    end

    if (current_state == ST_GUESS_J1)      last_player_d = 2'd1;
    else if (current_state == ST_GUESS_J2) last_player_d = 2'd2;

    if (entry) begin
      blink_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (is_win) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        visible_d   = ~visible_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRY_DIGITS; i++) begin
      entry_code[i] = digit_code(entry_digits[4*i +: 4]);
    end

    d_d = {NUM_DIGITS{CODE_BLANK}};
    if (is_secret || is_guess || (is_win && visible_q)) begin
      d_d[NUM_DIGITS-1] = CODE_J;
      d_d[NUM_DIGITS-2] = player_code;
      for (int i = 0; i < ENTRY_DIGITS; i++) begin
        d_d[i] = (is_secret && mask_q) ? CODE_DASH : entry_code[i];
      end
    end else if (current_state == ST_RESULT) begin
      d_d[NUM_DIGITS-1] = CODE_J;
      d_d[NUM_DIGITS-2] = CODE_W'(last_player_q);
      d_d[3]            = CODE_B;
      d_d[2]            = count_code(bulls);
      d_d[1]            = CODE_C;
      d_d[0]            = count_code(cows);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      confirm_prev_q <= 1'b0;
      prev_state_q   <= ST_IDLE;
      mask_q         <= 1'b1;
      last_player_q  <= 2'd1;
      blink_cnt_q    <= '0;
      visible_q      <= 1'b1;
      d_q            <= {NUM_DIGITS{CODE_BLANK}};
    end else begin
      confirm_prev_q <= confirm;
      prev_state_q   <= current_state;
      mask_q         <= mask_d;
      last_player_q  <= last_player_d;
      blink_cnt_q    <= blink_cnt_d;
      visible_q      <= visible_d;
      d_q            <= d_d;
    end
  end

  assign d = d_q;

endmodule
